// File: rtl/mcs_bridge_pkg.sv
// Shared types and helpers for the MCS-to-FPro bridge.
// Holds the FSM state type, error data default and wait-state lookup.
package mcs_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hdead_beef;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // 4-bit wait-state field of a region, region 0 in the LSBs
  function automatic logic [3:0] ws_of(
    input logic [31:0] ws,
    input int          region
  );
    return ws[region*4 +: 4];
  endfunction

endpackage

// File: rtl/mcs_fpro_bridge_ws_decode.sv
// Combinational address decode for the MCS-to-FPro bridge.
// Produces base match, region index, one-hot select and word address.
module bridge_decode
  import mcs_bridge_pkg::*;
#(
  parameter logic [31:0] BRG_BASE = 32'hc000_0000,
  parameter int          N_REGION = 4,
  parameter int          ADDR_W   = 21,
  localparam int         RW       = clog2(N_REGION)
) (
  input  logic [31:0]         address,
  output logic                hit,
  output logic [RW-1:0]       region,
  output logic [N_REGION-1:0] onehot,
  output logic [ADDR_W-1:0]   word_addr
);

  logic unused_lsb;

  assign unused_lsb = ^address[1:0];
  assign hit        = address[31:24] == BRG_BASE[31:24];
  assign region     = address[23 -: RW];
  assign word_addr  = address[ADDR_W+1:2];

  always_comb begin
    onehot         = '0;
    onehot[region] = 1'b1;
  end

endmodule

// File: rtl/mcs_fpro_bridge_ws.sv
// MCS IO-bus to multi-region FPro bridge with per-region read
// wait states, byte-masked writes and sticky error reporting.
module mcs_fpro_bridge_ws
  import mcs_bridge_pkg::*;
#(
  parameter logic [31:0]           BRG_BASE = 32'hc000_0000,
  parameter int                    N_REGION = 4,
  parameter int                    ADDR_W   = 21,
  parameter logic [4*N_REGION-1:0] RD_WS    = {4'd0, 4'd0, 4'd2, 4'd0},
  parameter logic [31:0]           ERR_DATA = ERR_DATA_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                io_addr_strobe,
  input  logic                io_read_strobe,
  input  logic                io_write_strobe,
  input  logic [3:0]          io_byte_enable,
  input  logic [31:0]         io_address,
  input  logic [31:0]         io_write_data,
  output logic [31:0]         io_read_data,
  output logic                io_ready,
  output logic [N_REGION-1:0] fp_cs,
  output logic                fp_wr,
  output logic                fp_rd,
  output logic [ADDR_W-1:0]   fp_addr,
  output logic [31:0]         fp_wr_data,
  output logic [3:0]          fp_be,
  input  logic [31:0]         fp_rd_data,
  input  logic                err_clr,
  output logic                bus_err,
  output logic                ovr_err
);

  localparam int          RW     = clog2(N_REGION);
  localparam logic [31:0] WS_VEC = 32'(RD_WS);

  state_t               state;
  logic [3:0]           cnt;
  logic [RW-1:0]        rgn;
  logic                 is_rd;

  logic                 dec_hit;
  logic [RW-1:0]        dec_rgn;
  logic [N_REGION-1:0]  dec_onehot;
  logic [ADDR_W-1:0]    dec_addr;
  logic [3:0]           cur_ws;
  logic                 legal;

  bridge_decode #(
    .BRG_BASE (BRG_BASE),
    .N_REGION (N_REGION),
    .ADDR_W   (ADDR_W)
  ) u_dec (
    .address   (io_address),
    .hit       (dec_hit),
    .region    (dec_rgn),
    .onehot    (dec_onehot),
    .word_addr (dec_addr)
  );

  assign cur_ws = ws_of(WS_VEC, int'(rgn));
  assign legal  = dec_hit && (io_read_strobe ^ io_write_strobe);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      rgn          <= '0;
      is_rd        <= 1'b0;
      io_read_data <= '0;
      io_ready     <= 1'b0;
      fp_cs        <= '0;
      fp_wr        <= 1'b0;
      fp_rd        <= 1'b0;
      fp_addr      <= '0;
      fp_wr_data   <= '0;
      fp_be        <= '0;
      bus_err      <= 1'b0;
      ovr_err      <= 1'b0;
    end else begin
      fp_wr    <= 1'b0;
      fp_rd    <= 1'b0;
      io_ready <= 1'b0;
      if (err_clr) begin
        bus_err <= 1'b0;
        ovr_err <= 1'b0;
      end
      // set events are written after the clear so they win
      if (io_addr_strobe && state != ST_IDLE)
        ovr_err <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (io_addr_strobe) begin
            if (legal) begin
              state      <= ST_ACCESS;
              rgn        <= dec_rgn;
              is_rd      <= io_read_strobe;
              fp_cs      <= dec_onehot;
              fp_wr      <= io_write_strobe;
              fp_rd      <= io_read_strobe;
              fp_addr    <= dec_addr;
              fp_wr_data <= io_write_data;
              fp_be      <= io_read_strobe ? 4'hf
                                           : io_byte_enable;
            end else begin
              state        <= ST_ERR;
              io_ready     <= 1'b1;
              io_read_data <= ERR_DATA;
            end
          end
        end
        ST_ACCESS: begin
          if (is_rd && cur_ws != 4'd0) begin
            cnt   <= cur_ws;
            state <= ST_WAIT;
          end else begin
            state        <= ST_RESP;
            io_ready     <= 1'b1;
            fp_cs        <= '0;
            io_read_data <= is_rd ? fp_rd_data : '0;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state        <= ST_RESP;
            io_ready     <= 1'b1;
            fp_cs        <= '0;
            io_read_data <= fp_rd_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_ERR: begin
          state   <= ST_IDLE;
          bus_err <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
